// File: rtl/mini_src_control_unit_if.sv
// Control bundle between the Mini SRC control unit (master) and the datapath (slave).
// mem_ready exists only when MEM_WAIT_EN is defined.
interface mini_src_control_unit_if;
  logic [31:0] ir;
  logic        con_ff;
  logic        stop;
`ifdef MEM_WAIT_EN
  logic        mem_ready;
`endif
  logic        run;
  logic [2:0]  step;
  logic [4:0]  opcode;
  logic PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out, LO_reg_out;
  logic InPortout, Cout, BAout, Rout;
  logic MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin, HI_reg_in, LO_reg_in;
  logic Rin, CON_enable, Output_in;
  logic Gra, Grb, Grc, R15_sel;
  logic IncPC, Read, Write;

  modport master (
`ifdef MEM_WAIT_EN
    input  mem_ready,
`endif
    input  ir, con_ff, stop,
    output run, step, opcode,
    output PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out, LO_reg_out,
    output InPortout, Cout, BAout, Rout,
    output MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin, HI_reg_in, LO_reg_in,
    output Rin, CON_enable, Output_in,
    output Gra, Grb, Grc, R15_sel,
    output IncPC, Read, Write
  );

  modport slave (
`ifdef MEM_WAIT_EN
    output mem_ready,
`endif
    output ir, con_ff, stop,
    input  run, step, opcode,
    input  PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out, LO_reg_out,
    input  InPortout, Cout, BAout, Rout,
    input  MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin, HI_reg_in, LO_reg_in,
    input  Rin, CON_enable, Output_in,
    input  Gra, Grb, Grc, R15_sel,
    input  IncPC, Read, Write
  );
endinterface

// File: rtl/mini_src_control_unit.sv
// Mini SRC hardwired control: fetch T0-T2, decode ir[31:27], execute T3-T7, halt/stop.
// Optional MEM_WAIT_EN: Read/Write steps stretch until mem_ready is high.
module mini_src_control_unit #(
  parameter int NUM_STEPS = 8
) (
  input logic                     clk,
  input logic                     clr,
  mini_src_control_unit_if.master bus
);
  localparam int STEP_W = $clog2(NUM_STEPS);
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3 = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4 = STEP_W'(4);
  localparam logic [STEP_W-1:0] T5 = STEP_W'(5);
  localparam logic [STEP_W-1:0] T6 = STEP_W'(6);
  localparam logic [STEP_W-1:0] T7 = STEP_W'(7);

  typedef enum logic [1:0] {M_RESET, M_RUN, M_HALTED, M_STOPPED} mode_t;
  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_UNARY, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } cls_t;

  mode_t             mode, mode_nxt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic [4:0]        op;
  cls_t              cls;
  logic              mem_hold;
  logic              unused_ir;

  function automatic cls_t classify(input logic [4:0] o);
    if (o == 5'd0)       return C_LD;
    else if (o == 5'd1)  return C_LDI;
    else if (o == 5'd2)  return C_ST;
    else if (o <= 5'd11) return C_ALU;
    else if (o <= 5'd14) return C_IMM;
    else if (o <= 5'd16) return C_MULDIV;
    else if (o <= 5'd18) return C_UNARY;
    else if (o == 5'd19) return C_BR;
    else if (o == 5'd20) return C_JR;
    else if (o == 5'd21) return C_JAL;
    else if (o == 5'd22) return C_IN;
    else if (o == 5'd23) return C_OUT;
    else if (o == 5'd24) return C_MFHI;
    else if (o == 5'd25) return C_MFLO;
    else if (o == 5'd27) return C_HALT;
    else                 return C_NOP;
  endfunction

  // Final step of each class; never below T2, so fetch steps cannot end early.
  function automatic logic [STEP_W-1:0] last_step(input cls_t c);
    unique case (c)
      C_LD, C_ST:                       return T7;
      C_LDI, C_ALU, C_IMM:              return T5;
      C_MULDIV, C_BR:                   return T6;
      C_UNARY, C_JAL:                   return T4;
      C_JR, C_IN, C_OUT, C_MFHI, C_MFLO: return T3;
      default:                          return T2;
    endcase
  endfunction

  assign op        = bus.ir[31:27];
  assign cls       = classify(op);
  assign unused_ir = ^bus.ir[26:0];
  assign bus.step  = 3'(step_cnt);

`ifdef MEM_WAIT_EN
  logic mem_step;
  assign mem_step = (mode == M_RUN) &&
                    ((step_cnt == T1) || (cls == C_LD && step_cnt == T6) ||
                     (cls == C_ST && step_cnt == T7));
  assign mem_hold = mem_step & ~bus.mem_ready;
`else
  assign mem_hold = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mode     <= M_RESET;
      step_cnt <= T0;
    end else begin
      mode     <= mode_nxt;
      step_cnt <= step_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode;
    step_nxt = step_cnt;
    unique case (mode)
      M_RESET: begin
        mode_nxt = M_RUN;
        step_nxt = T0;
      end
      M_RUN: begin
        if (!mem_hold) begin
          if (step_cnt == last_step(cls)) begin
            step_nxt = T0;
            if (cls == C_HALT)  mode_nxt = M_HALTED;
            else if (bus.stop)  mode_nxt = M_STOPPED;
          end else begin
            step_nxt = step_cnt + 1'b1;
          end
        end
      end
      M_STOPPED: if (!bus.stop) mode_nxt = M_RUN;
      M_HALTED:  mode_nxt = M_HALTED;
    endcase
  end

  always_comb begin
    bus.run = 1'b0;  bus.opcode = 5'b0;
    bus.PCout = 1'b0; bus.Z_hi_reg_out = 1'b0; bus.Z_lo_reg_out = 1'b0;
    bus.MDR_reg_out = 1'b0; bus.HI_reg_out = 1'b0; bus.LO_reg_out = 1'b0;
    bus.InPortout = 1'b0; bus.Cout = 1'b0; bus.BAout = 1'b0; bus.Rout = 1'b0;
    bus.MARin = 1'b0; bus.MDR_reg_in = 1'b0; bus.PCin = 1'b0; bus.IR_reg_in = 1'b0;
    bus.Y_reg_in = 1'b0; bus.Zin = 1'b0; bus.HI_reg_in = 1'b0; bus.LO_reg_in = 1'b0;
    bus.Rin = 1'b0; bus.CON_enable = 1'b0; bus.Output_in = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.R15_sel = 1'b0;
    bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
    if (mode == M_RUN) begin
      bus.run    = 1'b1;
      bus.opcode = OP_ADD;
      case (step_cnt)
        T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1; end
        T1: begin bus.Z_lo_reg_out = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDR_reg_in = 1'b1; end
        T2: begin bus.MDR_reg_out = 1'b1; bus.IR_reg_in = 1'b1; end
        default: begin
          unique case (cls)
            C_LD, C_LDI, C_ST: begin
              case (step_cnt)
                T3: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_reg_in = 1'b1; end
                T4: begin bus.Cout = 1'b1; bus.Zin = 1'b1; end
                T5: begin
                  bus.Z_lo_reg_out = 1'b1;
                  if (cls == C_LDI) begin bus.Gra = 1'b1; bus.Rin = 1'b1; end
                  else              bus.MARin = 1'b1;
                end
                T6: begin
                  bus.MDR_reg_in = 1'b1;
                  if (cls == C_ST) begin bus.Gra = 1'b1; bus.Rout = 1'b1; end
                  else             bus.Read = 1'b1;
                end
                T7: begin
                  if (cls == C_ST) bus.Write = 1'b1;
                  else begin bus.MDR_reg_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                end
                default: ;
              endcase
            end
            C_ALU, C_IMM: begin
              case (step_cnt)
                T3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Y_reg_in = 1'b1; end
                T4: begin
                  bus.Zin = 1'b1; bus.opcode = op;
                  if (cls == C_IMM) bus.Cout = 1'b1;
                  else begin bus.Grc = 1'b1; bus.Rout = 1'b1; end
                end
                T5: begin bus.Z_lo_reg_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                default: ;
              endcase
            end
            C_MULDIV: begin
              case (step_cnt)
                T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Y_reg_in = 1'b1; end
                T4: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op; end
                T5: begin bus.Z_lo_reg_out = 1'b1; bus.LO_reg_in = 1'b1; end
                T6: begin bus.Z_hi_reg_out = 1'b1; bus.HI_reg_in = 1'b1; end
                default: ;
              endcase
            end
            C_UNARY: begin
              case (step_cnt)
                T3: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op; end
                T4: begin bus.Z_lo_reg_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
                default: ;
              endcase
            end
            C_BR: begin
              case (step_cnt)
                T3: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CON_enable = 1'b1; end
                T4: begin bus.PCout = 1'b1; bus.Y_reg_in = 1'b1; end
                T5: begin bus.Cout = 1'b1; bus.Zin = 1'b1; end
                T6: begin bus.Z_lo_reg_out = 1'b1; bus.PCin = bus.con_ff; end
                default: ;
              endcase
            end
            C_JR:   if (step_cnt == T3) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
            C_JAL: begin
              case (step_cnt)
                T3: begin bus.PCout = 1'b1; bus.Rin = 1'b1; bus.R15_sel = 1'b1; end
                T4: begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                default: ;
              endcase
            end
            C_IN:   if (step_cnt == T3) begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            C_OUT:  if (step_cnt == T3) begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Output_in = 1'b1; end
            C_MFHI: if (step_cnt == T3) begin bus.HI_reg_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            C_MFLO: if (step_cnt == T3) begin bus.LO_reg_out = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
            C_NOP, C_HALT: ;
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mini_src_control_unit.sv
// Bench for mini_src_control_unit: queue-based instruction timeline model plus random instructions.
// MEM_WAIT_EN, when defined, also exercises the T1 memory wait.
module tb_mini_src_control_unit;
  localparam logic [27:0] PCOUT  = 28'd1 << 0,  ZHIOUT = 28'd1 << 1,  ZLOOUT = 28'd1 << 2;
  localparam logic [27:0] MDROUT = 28'd1 << 3,  HIOUT  = 28'd1 << 4,  LOOUT  = 28'd1 << 5;
  localparam logic [27:0] INPOUT = 28'd1 << 6,  COUT   = 28'd1 << 7,  BAOUT  = 28'd1 << 8;
  localparam logic [27:0] ROUT   = 28'd1 << 9,  MARIN  = 28'd1 << 10, MDRIN  = 28'd1 << 11;
  localparam logic [27:0] PCIN   = 28'd1 << 12, IRIN   = 28'd1 << 13, YIN    = 28'd1 << 14;
  localparam logic [27:0] ZIN    = 28'd1 << 15, HIIN   = 28'd1 << 16, LOIN   = 28'd1 << 17;
  localparam logic [27:0] RIN    = 28'd1 << 18, CONEN  = 28'd1 << 19, OUTIN  = 28'd1 << 20;
  localparam logic [27:0] GRA    = 28'd1 << 21, GRB    = 28'd1 << 22, GRC    = 28'd1 << 23;
  localparam logic [27:0] R15    = 28'd1 << 24, INCPC  = 28'd1 << 25, READ   = 28'd1 << 26;
  localparam logic [27:0] WRITE  = 28'd1 << 27;
  localparam logic [4:0]  ADD    = 5'b00011;

  typedef struct {
    logic        run;
    logic [2:0]  step;
    logic [4:0]  opc;
    logic [27:0] s;
    logic        full;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   n_vec = 0;
  int   n_err = 0;
  int   mstep;
  exp_t q[$];
  exp_t ce;
  logic [27:0] dut_s;
`ifdef MEM_WAIT_EN
  int   t1_wait = 0;
`endif

  mini_src_control_unit_if bus();
  mini_src_control_unit #(.NUM_STEPS(8)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  assign dut_s = {bus.Write, bus.Read, bus.IncPC, bus.R15_sel, bus.Grc, bus.Grb, bus.Gra,
                  bus.Output_in, bus.CON_enable, bus.Rin, bus.LO_reg_in, bus.HI_reg_in,
                  bus.Zin, bus.Y_reg_in, bus.IR_reg_in, bus.PCin, bus.MDR_reg_in, bus.MARin,
                  bus.Rout, bus.BAout, bus.Cout, bus.InPortout, bus.LO_reg_out,
                  bus.HI_reg_out, bus.MDR_reg_out, bus.Z_lo_reg_out, bus.Z_hi_reg_out,
                  bus.PCout};

  // One expected entry per clock; popped and compared at every falling edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      ce = q.pop_front();
      n_vec++;
      if (bus.run !== ce.run || dut_s !== ce.s ||
          (ce.full && (bus.step !== ce.step || bus.opcode !== ce.opc))) begin
        n_err++;
        $display("FAIL cycle @%0t: run %b want %b, step %0d want %0d, opcode %b want %b, strobes %h want %h (full=%b)",
                 $time, bus.run, ce.run, bus.step, ce.step, bus.opcode, ce.opc, dut_s, ce.s, ce.full);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic push_run(input logic [27:0] s, input logic [4:0] opc, input bit adv);
    exp_t e;
    e.run = 1'b1; e.step = 3'(mstep); e.opc = opc; e.s = s; e.full = 1'b1;
    q.push_back(e);
    if (adv) mstep++;
  endtask

  task automatic push_idle(input bit full);
    exp_t e;
    e.run = 1'b0; e.step = 3'd0; e.opc = 5'd0; e.s = 28'd0; e.full = full;
    q.push_back(e);
  endtask

  // Expected strobe timeline of one instruction, straight from the step tables.
  task automatic build_model(input logic [31:0] i, input logic cf, input int w, output int n);
    int n0;
    int op;
    n0 = q.size();
    op = int'(i[31:27]);
    mstep = 0;
    push_run(PCOUT | MARIN | INCPC | ZIN, ADD, 1);
    for (int k = 0; k < w; k++) push_run(ZLOOUT | PCIN | READ | MDRIN, ADD, 0);
    push_run(ZLOOUT | PCIN | READ | MDRIN, ADD, 1);
    push_run(MDROUT | IRIN, ADD, 1);
    if (op <= 2) begin
      push_run(GRB | BAOUT | YIN, ADD, 1);
      push_run(COUT | ZIN, ADD, 1);
      if (op == 1) push_run(ZLOOUT | GRA | RIN, ADD, 1);
      else begin
        push_run(ZLOOUT | MARIN, ADD, 1);
        if (op == 0) begin
          push_run(READ | MDRIN, ADD, 1);
          push_run(MDROUT | GRA | RIN, ADD, 1);
        end else begin
          push_run(GRA | ROUT | MDRIN, ADD, 1);
          push_run(WRITE, ADD, 1);
        end
      end
    end else if (op <= 14) begin
      push_run(GRB | ROUT | YIN, ADD, 1);
      push_run(((op >= 12) ? COUT : (GRC | ROUT)) | ZIN, 5'(op), 1);
      push_run(ZLOOUT | GRA | RIN, ADD, 1);
    end else if (op <= 16) begin
      push_run(GRA | ROUT | YIN, ADD, 1);
      push_run(GRB | ROUT | ZIN, 5'(op), 1);
      push_run(ZLOOUT | LOIN, ADD, 1);
      push_run(ZHIOUT | HIIN, ADD, 1);
    end else if (op <= 18) begin
      push_run(GRB | ROUT | ZIN, 5'(op), 1);
      push_run(ZLOOUT | GRA | RIN, ADD, 1);
    end else begin
      case (op)
        19: begin
          push_run(GRA | ROUT | CONEN, ADD, 1);
          push_run(PCOUT | YIN, ADD, 1);
          push_run(COUT | ZIN, ADD, 1);
          push_run(ZLOOUT | (cf ? PCIN : 28'd0), ADD, 1);
        end
        20: push_run(GRA | ROUT | PCIN, ADD, 1);
        21: begin
          push_run(PCOUT | RIN | R15, ADD, 1);
          push_run(GRA | ROUT | PCIN, ADD, 1);
        end
        22: push_run(INPOUT | GRA | RIN, ADD, 1);
        23: push_run(GRA | ROUT | OUTIN, ADD, 1);
        24: push_run(HIOUT | GRA | RIN, ADD, 1);
        25: push_run(LOOUT | GRA | RIN, ADD, 1);
        default: ;
      endcase
    end
    n = q.size() - n0;
  endtask

  task automatic drive(input logic [31:0] i, input logic cf, input int n, input int stop_cyc);
    for (int k = 0; k < stop_cyc; k++) push_idle(0);
    bus.ir = i; bus.con_ff = cf; bus.stop = (stop_cyc > 0);
`ifdef MEM_WAIT_EN
    bus.mem_ready = (t1_wait == 0);
`endif
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
`ifdef MEM_WAIT_EN
      if (c == t1_wait) bus.mem_ready = 1'b1;
`endif
    end
    for (int k = 0; k < stop_cyc; k++) begin
      if (k == stop_cyc - 1) bus.stop = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int cyc);
    clr = 1'b1;
    for (int k = 0; k <= cyc; k++) push_idle(1);
    #1;
    check("reset_run_low", 32'(bus.run), 32'd0);
    repeat (cyc) @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk); #1;
    check("t0_after_reset_run", 32'(bus.run), 32'd1);
  endtask

  initial begin
    int n;
    int w;
    logic [31:0] i;
    logic cf;
    int sc;
    clr = 1'b1;
    bus.ir = 32'd0; bus.con_ff = 1'b0; bus.stop = 1'b0;
`ifdef MEM_WAIT_EN
    bus.mem_ready = 1'b1;
`endif
    @(posedge clk); #1;
    do_reset(2);

    build_model(32'h03000002, 1'b0, 0, n);
    check("ld_len", 32'(n), 32'd8);
    check("ld_t3", 32'(q[3].s), 32'(GRB | BAOUT | YIN));
    check("ld_t6", 32'(q[6].s), 32'h0400_0800);
    check("ld_t7", 32'(q[7].s), 32'(MDROUT | GRA | RIN));
    drive(32'h03000002, 1'b0, n, 0);

    build_model(32'h18000000, 1'b0, 0, n);
    check("add_len", 32'(n), 32'd6);
    check("add_t4_opc", 32'(q[4].opc), 32'd3);
    check("add_t4_zin", 32'(q[4].s & ZIN), 32'h0000_8000);
    drive(32'h18000000, 1'b0, n, 0);

    build_model(32'h9B000019, 1'b0, 0, n);
    check("br_len", 32'(n), 32'd7);
    check("br_t6_nt", 32'(q[6].s), 32'h0000_0004);
    drive(32'h9B000019, 1'b0, n, 0);
    build_model(32'h9B000019, 1'b1, 0, n);
    check("br_t6_tk", 32'(q[6].s), 32'h0000_1004);
    drive(32'h9B000019, 1'b1, n, 0);

    build_model(32'hA0800000, 1'b0, 0, n);
    check("jr_len", 32'(n), 32'd4);
    drive(32'hA0800000, 1'b0, n, 0);

    build_model(32'h11000002, 1'b0, 0, n);
    check("st_len", 32'(n), 32'd8);
    check("st_t7", 32'(q[7].s), 32'(WRITE));
    drive(32'h11000002, 1'b0, n, 2);
    check("after_stop_run", 32'(bus.run), 32'd1);

`ifdef MEM_WAIT_EN
    t1_wait = 3;
    build_model(32'h18000000, 1'b0, 3, n);
    check("memwait_len", 32'(n), 32'd9);
    drive(32'h18000000, 1'b0, n, 0);
    t1_wait = 0;
`endif

    // add abandoned by clr during T5
    build_model(32'h18000000, 1'b0, 0, n);
    void'(q.pop_back());
    push_idle(1);
    push_idle(1);
    bus.ir = 32'h18000000; bus.con_ff = 1'b0; bus.stop = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #1 clr = 1'b1;
    #1;
    check("midreset_run", 32'(bus.run), 32'd0);
    check("midreset_strobes", 32'(dut_s), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;

    build_model(32'hD8000000, 1'b0, 0, n);
    check("halt_len", 32'(n), 32'd3);
    repeat (20) push_idle(0);
    bus.ir = 32'hD8000000;
    repeat (23) begin @(posedge clk); #1; end
    check("halt_stays", 32'(bus.run), 32'd0);
    do_reset(1);

    for (int k = 0; k < 200; k++) begin
      i = $urandom;
      if (i[31:27] == 5'd27) i[31:27] = 5'd26;
      cf = 1'($urandom);
      sc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      w = 0;
`ifdef MEM_WAIT_EN
      if ($urandom_range(0, 3) == 0) w = int'($urandom_range(1, 2));
      t1_wait = w;
`endif
      build_model(i, cf, w, n);
      drive(i, cf, n, sc);
    end

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mini_src_control_unit.md
Name: mini_src_control_unit

Overview:
Hardwired control FSM that sequences the Mini SRC datapath. It runs fetch (T0-T2), decodes IR[31:27], and drives every datapath strobe for each execute step (T3-T7). Its ports connect 1:1 to the datapath control inputs, replacing bench-driven signal sequencing. It supplies `opcode` to the ALU and implements halt and stop.

Parameters:
NUM_STEPS, 8, number of step states T0..T7; sizes the step counter.

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
ir  in  32  IR contents; opcode = ir[31:27]
con_ff  in  1  branch condition flip-flop output from the CON FF logic
stop  in  1  pause request, honoured at instruction boundary
run  out  1  high while executing; low in HALTED, STOPPED and RESET
step  out  3  current step index, for debug
opcode  out  5  ALU operation select
PCout, Z_hi_reg_out, Z_lo_reg_out, MDR_reg_out, HI_reg_out, LO_reg_out, InPortout, Cout, BAout, Rout  out  1 each  bus drive strobes
MARin, MDR_reg_in, PCin, IR_reg_in, Y_reg_in, Zin, HI_reg_in, LO_reg_in, Rin, CON_enable, Output_in  out  1 each  register load strobes
Gra, Grb, Grc, R15_sel  out  1 each  register-select controls; R15_sel forces R15 as the Rin target
IncPC, Read, Write  out  1 each  PC increment; MDR source select and memory read; memory write

Behaviour:
- clr high (asynchronous): state=RESET, all outputs 0, run=0. First clk edge with clr low moves to T0, run=1.
- Each step lasts 1 cycle. Outputs are a Moore decode of {state, ir[31:27]}. Only strobes listed below are 1; all others are 0. `opcode` is 5'b00011 (ADD) except where noted.
- T0: PCout, MARin, IncPC, Zin (Z<=PC+1).
- T1: Z_lo_reg_out, PCin, Read, MDR_reg_in.
- T2: MDR_reg_out, IR_reg_in.
- ld (00000): T3 Grb,BAout,Y_reg_in | T4 Cout,Zin | T5 Z_lo_reg_out,MARin | T6 Read,MDR_reg_in | T7 MDR_reg_out,Gra,Rin.
- ldi (00001): T3 as ld | T4 as ld | T5 Z_lo_reg_out,Gra,Rin.
- st (00010): T3-T5 as ld | T6 Gra,Rout,MDR_reg_in (Read=0) | T7 Write.
- R-type (00011-01011): T3 Grb,Rout,Y_reg_in | T4 Grc,Rout,Zin, opcode=ir[31:27] | T5 Z_lo_reg_out,Gra,Rin.
- addi/andi/ori (01100-01110): as R-type, but T4 uses Cout instead of Grc,Rout.
- mul/div (01111,10000): T3 Gra,Rout,Y_reg_in | T4 Grb,Rout,Zin, opcode=op | T5 Z_lo_reg_out,LO_reg_in | T6 Z_hi_reg_out,HI_reg_in.
- neg/not (10001,10010): T3 Grb,Rout,Zin, opcode=op | T4 Z_lo_reg_out,Gra,Rin.
- br (10011): T3 Gra,Rout,CON_enable | T4 PCout,Y_reg_in | T5 Cout,Zin | T6 Z_lo_reg_out, PCin=con_ff.
- jr (10100): T3 Gra,Rout,PCin.
- jal (10101): T3 PCout,Rin,R15_sel | T4 Gra,Rout,PCin.
- in (10110): T3 InPortout,Gra,Rin.
- out (10111): T3 Gra,Rout,Output_in.
- mfhi (11000): T3 HI_reg_out,Gra,Rin.
- mflo (11001): T3 LO_reg_out,Gra,Rin.
- nop (11010), and undefined opcodes 11100-11111: T2 → T0.
- halt (11011): T2 → HALTED. run=0, all strobes 0. Exit only via clr.
- Instruction end: after the last listed step, go to T0, or to STOPPED if stop=1. STOPPED: run=0, strobes 0; returns to T0 the cycle after stop=0.
- Latency: fetch 3 cycles; ld and st 8 total; br 7; jr 4.
- Reset mid-instruction: outputs drop to 0 immediately; the partial instruction is abandoned.

Optional Feature:
MEM_WAIT_EN
- Defined: adds input `mem_ready`. In any step asserting Read or Write (T1; ld T6; st T7), the FSM holds that step with all its strobes asserted until mem_ready=1, then advances.
- Undefined: the port is absent and every step is one cycle.

Test Plan:
- clr pulse mid-T5 of an add → all outputs 0 within the same cycle, run=0; T0 on the first edge after release.
- ir=0x03000002 (ld r6,2(r0)) → 8 cycles T0-T7; T3 Grb&BAout&Y_reg_in; T6 Read&MDR_reg_in; T7 Gra&Rin; then T0.
- ir=0x18000000 (add) → opcode=00011 with Zin at T4; Z_lo_reg_out&Rin at T5; 6 cycles total.
- ir=0x9B000019 (br) with con_ff=0 → PCin=0 at T6; repeat with con_ff=1 → PCin=1 at T6.
- ir=0xD8000000 (halt) → run falls after T2 and stays 0 for 20 cycles; recovers only on clr.
- stop=1 during st → Write at T7, then STOPPED, run=0; stop=0 → T0 next cycle. With MEM_WAIT_EN and mem_ready held low 3 cycles at T1 → T1 lasts 4 cycles.
